td4_cpu: RTL
============

Name: td4_cpu

Overview:
- Parametrised single-cycle TD4-class CPU core; successor to the NOP-only core.
- Executes the full 12-instruction TD4 set: A/B registers, carry flag, input port, output port, and conditional/unconditional jumps.
- Fetches one instruction per enabled cycle from an external asynchronous ROM via adr/instr.
- Adds a clock-enable for single-stepping and a registered output port.

Parameters:
- WIDTH, 4, data/immediate/address width. Instruction word is {opcode[3:0], imm[WIDTH-1:0]}. Program space is 2**WIDTH words.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  execute enable; when 0 all state holds.
- adr  output  WIDTH  instruction address; equals PC (combinational from PC register).
- instr  input  4+WIDTH  instruction word for adr; sampled same cycle.
- in_port  input  WIDTH  data input port.
- out_port  output  WIDTH  registered output port.
- carry  output  1  current carry flag (debug/observe).

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset (sampled at a rising edge, overrides en): PC=0, A=0, B=0, C=0, out_port=0. Reset mid-program takes effect at the next edge; the instruction in flight is discarded.
- Datapath: single adder of WIDTH bits. Result = src + imm, where src is selected from A, B, in_port, or 0. Carry-out is bit WIDTH of the (WIDTH+1)-bit sum. Sums wrap modulo 2**WIDTH.
- One instruction completes per edge with en=1; latency 1 cycle. With en=0, PC/A/B/C/out_port hold; adr stays stable.
- Default PC update: PC <= PC+1 mod 2**WIDTH. PC wraps from 2**WIDTH-1 to 0.
- C update: C <= adder carry-out on every executed instruction. Only ADD can set it; all others clear it.
- Opcode decode (op=instr[WIDTH+3:WIDTH], im=instr[WIDTH-1:0]):
  - 0000 ADD A,im: A<=A+im.
  - 0001 MOV A,B: A<=B.
  - 0010 IN A: A<=in_port.
  - 0011 MOV A,im: A<=im.
  - 0100 MOV B,A: B<=A.
  - 0101 ADD B,im: B<=B+im.
  - 0110 IN B: B<=in_port.
  - 0111 MOV B,im: B<=im.
  - 1001 OUT B: out_port<=B.
  - 1011 OUT im: out_port<=im.
  - 1110 JNC im: PC<=im if C==0 (C as before this instruction), else PC+1.
  - 1111 JMP im: PC<=im.
  - 1000, 1010, 1100, 1101: NOP; only PC advances and C clears.
- All-zero instruction is ADD A,0: A unchanged, C<=0. A zero-filled ROM therefore behaves as NOP sweep with PC wrapping.
- JMP/JNC to the current address is legal and forms a halt loop.
- in_port is sampled only at the executing edge; no synchronisation inside the block.
- No X propagation: every state register is assigned in every branch.

Test Plan:
- Reset then ROM all 0x00, WIDTH=4: adr steps 0,1,…,15,0; A=0, C=0, out_port=0 throughout.
- ROM: MOV A,3; ADD A,14; JNC 0; OUT im 5; JMP 3 → A=1, C=1 after the ADD; JNC is not taken; out_port=5 at the 4th edge; adr then loops 3,4,3,4.
- ROM: MOV B,15; ADD B,1; JNC 5 → B=0, C=1; JNC falls through to adr 3. Repeat with ADD B,0: C=0, adr jumps to 5.
- in_port=0xA; ROM: IN A; MOV B,A; OUT B → out_port=0xA after 3 edges; C=0.
- en=0 for 3 cycles mid-program → adr, A, B, out_port, carry frozen; resume with en=1 continues at the same adr.
- Assert reset for one edge while PC=7, A=9, out_port=6 → next cycle adr=0, A=0, B=0, carry=0, out_port=0. WIDTH=8 rerun of the first scenario shows PC wrap at 255→0.

Source files
------------

// File: rtl/td4_cpu.sv
// TD4-class single-cycle CPU: A/B registers, carry flag, in/out ports, JNC/JMP, fetch from async ROM.
// Latency: one instruction retires per rising edge of clk while en is high; adr follows PC combinationally.
// Backpressure: en low freezes PC, A, B, carry and out_port; synchronous reset overrides en.
module td4_cpu #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] adr,
    input  logic [WIDTH+3:0] instr,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             carry
);

    typedef enum logic [3:0] {
        OP_ADD_A_IM = 4'b0000,
        OP_MOV_A_B  = 4'b0001,
        OP_IN_A     = 4'b0010,
        OP_MOV_A_IM = 4'b0011,
        OP_MOV_B_A  = 4'b0100,
        OP_ADD_B_IM = 4'b0101,
        OP_IN_B     = 4'b0110,
        OP_MOV_B_IM = 4'b0111,
        OP_OUT_B    = 4'b1001,
        OP_OUT_IM   = 4'b1011,
        OP_JNC      = 4'b1110,
        OP_JMP      = 4'b1111
    } op_t;

    typedef enum logic [1:0] {
        SRC_ZERO,
        SRC_A,
        SRC_B,
        SRC_IN
    } src_t;

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;

    logic [3:0]       op;
    logic [WIDTH-1:0] im;

    src_t             src_sel;
    logic             use_imm;
    logic             load_a;
    logic             load_b;
    logic             load_out;
    logic             jump;

    logic [WIDTH-1:0] src_val;
    logic [WIDTH-1:0] imm_eff;
    logic [WIDTH:0]   sum;

    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] b_next;
    logic [WIDTH-1:0] out_next;
    logic             c_next;

    assign op       = instr[WIDTH+3:WIDTH];
    assign im       = instr[WIDTH-1:0];
    assign adr      = pc;
    assign carry    = c;

    // Decode: pick adder source, whether the immediate feeds the adder, and the destination.
    // Non-ADD instructions add zero, so the adder carry is naturally cleared for them.
    always_comb begin
        src_sel  = SRC_ZERO;
        use_imm  = 1'b0;
        load_a   = 1'b0;
        load_b   = 1'b0;
        load_out = 1'b0;
        jump     = 1'b0;
        case (op)
            OP_ADD_A_IM: begin src_sel = SRC_A;    use_imm = 1'b1; load_a   = 1'b1; end
            OP_MOV_A_B:  begin src_sel = SRC_B;                    load_a   = 1'b1; end
            OP_IN_A:     begin src_sel = SRC_IN;                   load_a   = 1'b1; end
            OP_MOV_A_IM: begin                     use_imm = 1'b1; load_a   = 1'b1; end
            OP_MOV_B_A:  begin src_sel = SRC_A;                    load_b   = 1'b1; end
            OP_ADD_B_IM: begin src_sel = SRC_B;    use_imm = 1'b1; load_b   = 1'b1; end
            OP_IN_B:     begin src_sel = SRC_IN;                   load_b   = 1'b1; end
            OP_MOV_B_IM: begin                     use_imm = 1'b1; load_b   = 1'b1; end
            OP_OUT_B:    begin src_sel = SRC_B;                    load_out = 1'b1; end
            OP_OUT_IM:   begin                     use_imm = 1'b1; load_out = 1'b1; end
            OP_JNC:      jump = ~c;
            OP_JMP:      jump = 1'b1;
            default:     ;
        endcase
    end

    // Single shared adder: (WIDTH+1)-bit sum, top bit is the carry-out.
    always_comb begin
        case (src_sel)
            SRC_A:   src_val = a;
            SRC_B:   src_val = b;
            SRC_IN:  src_val = in_port;
            default: src_val = '0;
        endcase
        imm_eff = use_imm ? im : '0;
        sum     = {1'b0, src_val} + {1'b0, imm_eff};
    end

    // Next-state values; every register gets an explicit value each cycle.
    always_comb begin
        pc_next  = jump     ? im               : pc + WIDTH'(1);
        a_next   = load_a   ? sum[WIDTH-1:0]   : a;
        b_next   = load_b   ? sum[WIDTH-1:0]   : b;
        out_next = load_out ? sum[WIDTH-1:0]   : out_port;
        c_next   = sum[WIDTH];
    end

    // Architectural state: reset wins, otherwise update only on enabled cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= '0;
            a        <= '0;
            b        <= '0;
            c        <= 1'b0;
            out_port <= '0;
        end else if (en) begin
            pc       <= pc_next;
            a        <= a_next;
            b        <= b_next;
            c        <= c_next;
            out_port <= out_next;
        end else begin
            pc       <= pc;
            a        <= a;
            b        <= b;
            c        <= c;
            out_port <= out_port;
        end
    end

endmodule
